input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_if.sv | 21 ++
 rtl/input_conditioner.sv | 143 ++++++++++++++
 tb/tb_input_conditioner.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/input_conditioner_if.sv
// Raw-input / conditioned-output bundle for input_conditioner.
// The slave side is the conditioner itself; the master side is whatever
// drives the raw lines and consumes the conditioned events.
interface input_conditioner_if;
  logic raw_c1;
  logic raw_c2;
  logic raw_i;
  logic c1_pulse;
  logic c2_pulse;
  logic i_level;

  modport slave (
    input  raw_c1, raw_c2, raw_i,
    output c1_pulse, c2_pulse, i_level
  );

  modport master (
    output raw_c1, raw_c2, raw_i,
    input  c1_pulse, c2_pulse, i_level
  );
endinterface

// File: rtl/input_conditioner.sv
// Three-channel input conditioner: 2-flop synchronizer plus debounce FSM per
// channel. Channels 1 and 2 produce one-cycle rise pulses that never overlap;
// channel I produces a registered debounced level.
module input_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input logic                 clk,
  input logic                 reset,
  input_conditioner_if.slave  bus
);

  localparam int NCH  = 3;
  localparam int CH_C1 = 0;
  localparam int CH_C2 = 1;
  localparam int CH_I  = 2;

  // Counter value at which the last required stable sample is seen.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    CHK_HIGH,
    HIGH,
    CHK_LOW
  } deb_state_t;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] rise;
  logic           c2_pending;
  logic           i_level_next;

  assign raw = {bus.raw_i, bus.raw_c2, bus.raw_c1};

  // Two-stage synchronizer; sync2 is the channel sample seen by the FSMs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Rise event: last qualifying high sample while checking a rising edge.
    assign rise[g] = (state == CHK_HIGH) && sync2[g] && (cnt == CNT_LAST);

    // Debounce FSM: a level change is accepted only after a run of
    // DEB_CYCLES+1 agreeing samples; cnt is cleared on every state change.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= LOW;
        cnt   <= '0;
      end else begin
        unique case (state)
          LOW: begin
            if (sync2[g]) begin
              state <= CHK_HIGH;
              cnt   <= '0;
            end
          end
          CHK_HIGH: begin
            if (!sync2[g]) begin
              state <= LOW;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= HIGH;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HIGH: begin
            if (!sync2[g]) begin
              state <= CHK_LOW;
              cnt   <= '0;
            end
          end
          CHK_LOW: begin
            if (sync2[g]) begin
              state <= HIGH;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= LOW;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= LOW;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Debounced level of channel I as it will be after the coming edge.
  // NOTE: the default assignment first guarantees no latch is inferred even
  // if a case arm forgets to drive the signal.
  always_comb begin
    i_level_next = 1'b0;
    unique case (g_chan[CH_I].state)
      LOW:      i_level_next = 1'b0;
      CHK_HIGH: i_level_next = rise[CH_I];
      HIGH:     i_level_next = 1'b1;
      CHK_LOW:  i_level_next = sync2[CH_I] || (g_chan[CH_I].cnt != CNT_LAST);
      default:  i_level_next = 1'b0;
    endcase
  end

  // Output register: c1 always wins a tie, a simultaneous c2 rise is parked
  // in c2_pending and issued on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.c1_pulse <= 1'b0;
      bus.c2_pulse <= 1'b0;
      bus.i_level  <= 1'b0;
      c2_pending   <= 1'b0;
    end else begin
      bus.c1_pulse <= rise[CH_C1];
      bus.i_level  <= i_level_next;
      if (rise[CH_C1]) begin
        bus.c2_pulse <= 1'b0;
        c2_pending   <= c2_pending | rise[CH_C2];
      end else begin
        bus.c2_pulse <= c2_pending | rise[CH_C2];
        c2_pending   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEB_CYCLES=4. A behavioural
// model (sample pipeline, run-length acceptance, owed-pulse counter) predicts
// every output on every cycle; directed scenarios add latency/count checks.
module tb_input_conditioner;

  localparam int DEB   = 4;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEB_CYCLES(DEB),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, per channel (0=c1, 1=c2, 2=i).
  bit m_sync1 [3];
  bit m_sync2 [3];
  bit m_level [3];
  int m_run   [3];
  int c2_owed;
  bit exp_c1, exp_c2, exp_i;

  // Observed-event counters for directed scenarios.
  int n_c1, n_c2, n_itog;
  bit prev_i;

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_sync1[ch] = 1'b0;
      m_sync2[ch] = 1'b0;
      m_level[ch] = 1'b0;
      m_run[ch]   = 0;
    end
    c2_owed = 0;
    exp_c1  = 1'b0;
    exp_c2  = 1'b0;
    exp_i   = 1'b0;
  endtask

  // One rising edge of the reference: a level flips once DEB+1 consecutive
  // synchronized samples disagree with it; rises become owed pulses.
  task automatic model_edge(input bit r1, input bit r2, input bit ri);
    bit raw [3];
    bit rise [3];
    bit s;
    raw[0] = r1;
    raw[1] = r2;
    raw[2] = ri;
    for (int ch = 0; ch < 3; ch++) begin
      s = m_sync2[ch];
      m_sync2[ch] = m_sync1[ch];
      m_sync1[ch] = raw[ch];
      rise[ch] = 1'b0;
      if (s != m_level[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == DEB + 1) begin
          m_level[ch] = s;
          m_run[ch]   = 0;
          rise[ch]    = s;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
    exp_c1 = rise[0];
    if (rise[1]) c2_owed++;
    if (!rise[0] && c2_owed > 0) begin
      exp_c2 = 1'b1;
      c2_owed--;
    end else begin
      exp_c2 = 1'b0;
    end
    exp_i = m_level[2];
  endtask

  // Drive inputs on the falling edge, advance one rising edge, compare #1 later.
  task automatic step(input bit r1, input bit r2, input bit ri, input bit rst);
    @(negedge clk);
    bus.raw_c1 = r1;
    bus.raw_c2 = r2;
    bus.raw_i  = ri;
    reset      = rst;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(r1, r2, ri);
    #1;
    check("c1_pulse", bus.c1_pulse, exp_c1);
    check("c2_pulse", bus.c2_pulse, exp_c2);
    check("i_level",  bus.i_level,  exp_i);
    check("pulse_exclusive", bus.c1_pulse & bus.c2_pulse, 1'b0);
    if (bus.c1_pulse === 1'b1) n_c1++;
    if (bus.c2_pulse === 1'b1) n_c2++;
    if (bus.i_level !== prev_i) n_itog++;
    prev_i = bus.i_level;
  endtask

  task automatic clear_counts();
    n_c1   = 0;
    n_c2   = 0;
    n_itog = 0;
    prev_i = bus.i_level;
  endtask

  initial begin
    bit r1, r2, ri;
    int rise_at;

    bus.raw_c1 = 1'b0;
    bus.raw_c2 = 1'b0;
    bus.raw_i  = 1'b0;
    reset      = 1'b1;
    model_reset();
    prev_i = 1'b0;

    // Reset state, with raw inputs toggling underneath.
    #2;
    check("reset_c1", bus.c1_pulse, 1'b0);
    check("reset_c2", bus.c2_pulse, 1'b0);
    check("reset_i",  bus.i_level,  1'b0);
    for (int k = 0; k < 3; k++) step(k[0], ~k[0], k[0], 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Single c1 rise held: pulse only in the cycle after edge 6.
    clear_counts();
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("c1_latency", bus.c1_pulse, k == DEB + 2);
    end
    check_int("c1_single_count", n_c1, 1);
    check_int("c2_quiet_count", n_c2, 0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // c2 glitch of DEB cycles: no pulse, i_level stays low.
    clear_counts();
    for (int k = 0; k < DEB; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)  step(1'b0, 1'b0, 1'b0, 1'b0);
    check_int("c2_glitch_count", n_c2, 0);
    check_int("glitch_i_toggles", n_itog, 0);

    // Simultaneous rise: c1 after edge 6, c2 after edge 7.
    clear_counts();
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("both_c1_edge", bus.c1_pulse, k == DEB + 2);
      check("both_c2_edge", bus.c2_pulse, k == DEB + 3);
    end
    check_int("both_c1_count", n_c1, 1);
    check_int("both_c2_count", n_c2, 1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // raw_i: 1, bounce for 10 cycles ending on 1, then stable 1. The last
    // raw change lands between edge 9 and edge 10; i_level rises at edge 16.
    clear_counts();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, k[0] ? 1'b0 : 1'b1, 1'b0);
      check("bounce_i_low", bus.i_level, 1'b0);
    end
    for (int k = 11; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("i_rise_edge", bus.i_level, k >= 9 + DEB + 3);
    end
    check_int("i_toggle_count", n_itog, 1);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // c1 held, reset pulsed mid-debounce; one pulse 6 edges after release.
    clear_counts();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_int("reset_discard_count", n_c1, 0);
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("post_reset_edge", bus.c1_pulse, k == DEB + 2);
    end
    check_int("post_reset_count", n_c1, 1);

    // c1 high 20, low 20, high 20: exactly two pulses.
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    clear_counts();
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_int("hold_twice_count", n_c1, 2);

    // Randomized traffic: long holds mixed with bounce and rare resets.
    r1 = 1'b0;
    r2 = 1'b0;
    ri = 1'b0;
    rise_at = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) r1 = ~r1;
      if ($urandom_range(0, 9) == 0) r2 = ~r2;
      if ($urandom_range(0, 7) == 0) ri = ~ri;
      // Occasionally force both lines to rise together to hit the tie path.
      if ($urandom_range(0, 99) == 0) begin
        r1 = 1'b1;
        r2 = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) rise_at = 2;
      step(r1, r2, ri, rise_at > 0);
      if (rise_at > 0) rise_at--;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
